// File: rtl/seq_chk_pkg.sv
// Shared types and constants for the sequence checker: state encoding,
// default parameter values and the sample width.
package seq_chk_pkg;

  localparam int DATA_W       = 8;
  localparam int STEP_DEF     = 1;
  localparam int SYNC_LEN_DEF = 4;
  localparam int LOSS_LEN_DEF = 3;
  localparam int CNT_W_DEF    = 16;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Bits needed to hold a run length that counts up to len-1.
  function automatic int run_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment
// and the count holds once it reaches all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sequence_checker.sv
// Receive-side checker for an arithmetic 8-bit sequence: HUNT/SYNC/LOCKED
// tracking with flywheel, error pulses and saturating counters.
// Optional first-error capture ports are enabled by SEQ_CHK_ERR_CAPTURE_EN.
module sequence_checker
  import seq_chk_pkg::*;
#(
  parameter int STEP     = STEP_DEF,
  parameter int SYNC_LEN = SYNC_LEN_DEF,
  parameter int LOSS_LEN = LOSS_LEN_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] data,
  input  logic              clear,
  output logic              locked,
  output logic              err,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  sample_count,
  output logic [DATA_W-1:0] expected
`ifdef SEQ_CHK_ERR_CAPTURE_EN
  ,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act,
  output logic              first_err_valid
`endif
);

  localparam int MR_W = run_w(SYNC_LEN);
  localparam int LR_W = run_w(LOSS_LEN);
  localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);

  state_t            state_q, state_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] expected_q, expected_d;
  logic [MR_W-1:0]   match_run_q, match_run_d;
  logic [LR_W-1:0]   miss_run_q, miss_run_d;

  logic match;
  logic acc_locked;

  assign match      = (data == expected_q);
  assign acc_locked = enable && (state_q == LOCKED);

  always_comb begin
    state_d     = state_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    expected_d  = expected_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    if (enable) begin
      case (state_q)
        HUNT: begin
          expected_d  = data + STEP_V;
          match_run_d = '0;
          if (SYNC_LEN == 1) begin
            state_d    = LOCKED;
            locked_d   = 1'b1;
            miss_run_d = '0;
          end else begin
            state_d = SYNC;
          end
        end
        SYNC: begin
          // Every SYNC sample reseeds from the received value; only the run length differs.
          expected_d = data + STEP_V;
          if (match) begin
            match_run_d = match_run_q + MR_W'(1);
            if (int'(match_run_q) + 1 == SYNC_LEN - 1) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              miss_run_d = '0;
            end
          end else begin
            match_run_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: prediction advances from itself, never from a bad sample.
          expected_d = expected_q + STEP_V;
          if (match) begin
            miss_run_d = '0;
          end else begin
            err_d = 1'b1;
            if (int'(miss_run_q) + 1 == LOSS_LEN) begin
              state_d    = HUNT;
              locked_d   = 1'b0;
              miss_run_d = '0;
            end else begin
              miss_run_d = miss_run_q + LR_W'(1);
            end
          end
        end
        default: begin
          state_d  = HUNT;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      expected_q  <= '0;
      match_run_q <= '0;
      miss_run_q  <= '0;
    end else begin
      state_q     <= state_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      expected_q  <= expected_d;
      match_run_q <= match_run_d;
      miss_run_q  <= miss_run_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (acc_locked && !match),
    .clr   (clear),
    .count (err_count)
  );

  sat_counter #(.W(CNT_W)) u_sample_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (acc_locked),
    .clr   (clear),
    .count (sample_count)
  );

  assign locked   = locked_q;
  assign err      = err_q;
  assign expected = expected_q;

`ifdef SEQ_CHK_ERR_CAPTURE_EN
  logic [DATA_W-1:0] cap_exp_q, cap_exp_d;
  logic [DATA_W-1:0] cap_act_q, cap_act_d;
  logic              cap_vld_q, cap_vld_d;

  always_comb begin
    cap_exp_d = cap_exp_q;
    cap_act_d = cap_act_q;
    cap_vld_d = cap_vld_q;
    if (clear) begin
      cap_exp_d = '0;
      cap_act_d = '0;
      cap_vld_d = 1'b0;
    end else if (acc_locked && !match && !cap_vld_q) begin
      cap_exp_d = expected_q;
      cap_act_d = data;
      cap_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_exp_q <= '0;
      cap_act_q <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      cap_exp_q <= cap_exp_d;
      cap_act_q <= cap_act_d;
      cap_vld_q <= cap_vld_d;
    end
  end

  assign first_err_exp   = cap_exp_q;
  assign first_err_act   = cap_act_q;
  assign first_err_valid = cap_vld_q;
`endif

endmodule

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
- Receive-side counterpart of sequence_generator: consumes the 8-bit data stream qualified by enable and checks it against the expected arithmetic sequence.
- Acquires lock, flywheels through isolated errors and drops lock after repeated mismatches.
- Reports lock status, per-sample error pulses and saturating error/sample counters.
- Sits directly on the generator's output bus in loopback benches and on-chip self-test.

Parameters:
- STEP, 1: expected increment between consecutive samples, modulo 256.
- SYNC_LEN, 4: consecutive matches required in SYNC to declare lock. Must be at least 1.
- LOSS_LEN, 3: consecutive mismatches in LOCKED that force a return to HUNT. Must be at least 1.
- CNT_W, 16: width of err_count and sample_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  data-valid qualifier; a sample is accepted on each rising clk edge with enable=1.
- data  input  8  sample value.
- clear  input  1  synchronous clear of both counters; does not change state.
- locked  output  1  high while the state is LOCKED.
- err  output  1  one-cycle pulse for each mismatching sample accepted in LOCKED.
- err_count  output  CNT_W  saturating count of LOCKED mismatches.
- sample_count  output  CNT_W  saturating count of samples accepted in LOCKED.
- expected  output  8  value predicted for the next sample.

Behaviour:
- Reset (rst_n=0, asynchronous): state=HUNT; locked, err, err_count, sample_count, expected, match_run and miss_run all 0.
- All outputs are registered and reflect an accepted sample one cycle after the accepting edge. enable=0 holds every register, and err=0 on that cycle.
- Arithmetic is 8-bit with wrap-around: 0xFF + 1 = 0x00.
- HUNT:
  - On a sample: expected <= data+STEP, match_run <= 0.
  - If SYNC_LEN=1, go to LOCKED; otherwise go to SYNC.
- SYNC:
  - Match (data==expected): match_run++, expected <= data+STEP. When match_run+1 == SYNC_LEN-1, go to LOCKED.
  - Mismatch: reseed with expected <= data+STEP, match_run <= 0, stay in SYNC.
  - err is never asserted in HUNT or SYNC.
- Lock count: including the seed sample, SYNC_LEN+... correction: SYNC_LEN consecutive correct samples, seed included, produce lock. Example with SYNC_LEN=4: samples 0,1,2,3 give locked=1 after the sample 3 edge.
- LOCKED:
  - Every sample increments sample_count, saturating.
  - Match: miss_run <= 0, expected <= expected+STEP.
  - Mismatch: err=1 for one cycle, err_count++ (saturating), miss_run++, and expected <= expected+STEP (flywheel, no reseed).
  - When miss_run+1 == LOSS_LEN: go to HUNT, locked <= 0, miss_run <= 0.
- Counters saturate at all-ones and hold there.
- clear=1: both counters go to 0 on that edge, overriding any increment on the same edge. err, locked, state and expected are unaffected.
- Reset mid-operation aborts immediately: state returns to HUNT and counters to 0.

Optional Feature:
- Macro: SEQ_CHK_ERR_CAPTURE_EN.
- Defined: adds outputs first_err_exp[8], first_err_act[8] and first_err_valid[1].
  - On the first LOCKED mismatch after reset or clear, capture expected and data and set first_err_valid.
  - Later mismatches do not overwrite the capture.
  - Reset or clear zeroes all three.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package seq_chk_pkg holds:
  - state typedef: HUNT=2'd0, SYNC=2'd1, LOCKED=2'd2;
  - default parameter constants;
  - data width constant (8).
- Sub-module sat_counter (parameter W; ports inc, clr, count), instantiated for err_count and sample_count.

Test Plan:
- Lock acquisition: reset, then feed 0x10..0x13 with enable=1 → locked=1 the cycle after 0x13, err never asserted, expected=0x14.
- Wrap and gaps: while locked, feed 0xFE,0xFF,0x00,0x01 with enable=0 cycles interleaved → no err, sample_count +4, expected=0x02.
- Isolated error and flywheel: locked expecting 0x20, feed 0x20,0x55,0x22 → one err pulse on the 0x55 sample, err_count=1, locked stays 1, expected=0x23.
- Loss of lock (LOSS_LEN=3): locked, feed 0xAA three times with expected values differing → three err pulses, err_count=3, locked=0 after the third, state HUNT.
- SYNC reseed: from HUNT feed 0x05,0x06,0x40,0x41,0x42,0x43 → no lock until after 0x43, no err pulses.
- Clear, saturation and reset:
  - With CNT_W=4, force more than 15 errors → err_count holds at 0xF.
  - Assert clear on an error sample → err_count=0 while err is still pulsed.
  - Drop rst_n mid-stream → all outputs 0 asynchronously.
